// File: rtl/core_ibex_stall_tracker.sv
// Per-channel ID-stage stall, longest-run and retire counters under an IDLE/RUN/SAT control FSM.
// Latency: 1 clk, all outputs registered; no backpressure, inputs are sampled every cycle.
module core_ibex_stall_tracker #(
    parameter int NumStallCh      = 5,
    parameter int CntWidth        = 16,
    parameter int LongStallThresh = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_ni,
    input  logic                                 en_i,
    input  logic                                 clear_i,
    input  logic                                 valid_id_i,
    input  logic                                 valid_wb_i,
    input  logic [NumStallCh-1:0]                stall_id_i,
    output logic [NumStallCh-1:0][CntWidth-1:0]  stall_cnt_o,
    output logic [NumStallCh-1:0][CntWidth-1:0]  max_run_o,
    output logic [CntWidth-1:0]                  retire_cnt_o,
    output logic [NumStallCh-1:0]                long_stall_o,
    output logic [1:0]                           state_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StSat  = 2'b10
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic [CntWidth-1:0] Thresh = CntWidth'(LongStallThresh);

    state_e                               state_q, state_d;
    logic [NumStallCh-1:0][CntWidth-1:0]  stall_cnt_q, stall_cnt_d;
    logic [NumStallCh-1:0][CntWidth-1:0]  max_run_q, max_run_d;
    logic [NumStallCh-1:0][CntWidth-1:0]  run_q, run_d;
    logic [CntWidth-1:0]                  retire_cnt_q, retire_cnt_d;
    logic [NumStallCh-1:0]                long_stall_q, long_stall_d;

    logic                                 counting;
    logic                                 sat_hit;
    logic [NumStallCh-1:0]                qual;
    logic [CntWidth-1:0]                  run_inc;

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        max_run_d    = max_run_q;
        run_d        = '0;
        retire_cnt_d = retire_cnt_q;
        long_stall_d = '0;
        sat_hit      = 1'b0;
        run_inc      = '0;
        qual         = stall_id_i & {NumStallCh{valid_id_i}};
        counting     = (state_q == StRun) && en_i;

        if (counting) begin
            for (int c = 0; c < NumStallCh; c++) begin
                if (qual[c]) begin
                    run_inc  = (run_q[c] == CntMax) ? CntMax : run_q[c] + CntOne;
                    run_d[c] = run_inc;
                    if (run_inc > max_run_q[c]) begin
                        max_run_d[c] = run_inc;
                    end
                    // Run only climbs within a stall, so the threshold is crossed once per run.
                    long_stall_d[c] = (run_inc == Thresh) && (run_q[c] != Thresh);
                    if (stall_cnt_q[c] != CntMax) begin
                        stall_cnt_d[c] = stall_cnt_q[c] + CntOne;
                        if (stall_cnt_d[c] == CntMax) begin
                            sat_hit = 1'b1;
                        end
                    end
                end
            end
            if (valid_wb_i && (retire_cnt_q != CntMax)) begin
                retire_cnt_d = retire_cnt_q + CntOne;
                if (retire_cnt_d == CntMax) begin
                    sat_hit = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle:  if (en_i) state_d = StRun;
            StRun:   begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (sat_hit) begin
                    state_d = StSat;
                end
            end
            StSat:   state_d = StSat;
            default: state_d = StIdle;
        endcase

        // The final saturating update lands, but SAT itself holds no live run or pulse.
        if (sat_hit) begin
            run_d        = '0;
            long_stall_d = '0;
        end

        if (clear_i) begin
            state_d      = StIdle;
            stall_cnt_d  = '0;
            max_run_d    = '0;
            run_d        = '0;
            retire_cnt_d = '0;
            long_stall_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            stall_cnt_q  <= '0;
            max_run_q    <= '0;
            run_q        <= '0;
            retire_cnt_q <= '0;
            long_stall_q <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            max_run_q    <= max_run_d;
            run_q        <= run_d;
            retire_cnt_q <= retire_cnt_d;
            long_stall_q <= long_stall_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign max_run_o    = max_run_q;
    assign retire_cnt_o = retire_cnt_q;
    assign long_stall_o = long_stall_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_core_ibex_stall_tracker.sv
// Directed and random stimulus against a cycle-level behavioural model of the stall tracker.
// A second, 4-bit instance exercises retire saturation and the SAT state.
module tb_core_ibex_stall_tracker;

    localparam int NCH  = 5;
    localparam int MAXA = 65535;
    localparam int TH   = 8;

    logic                      clk;
    logic                      rst_ni;
    logic                      en_i, clear_i, valid_id_i, valid_wb_i;
    logic [NCH-1:0]            stall_id_i;
    logic [NCH-1:0][15:0]      stall_cnt_o, max_run_o;
    logic [15:0]               retire_cnt_o;
    logic [NCH-1:0]            long_stall_o;
    logic [1:0]                state_o;

    logic                      b_en, b_clr, b_vid, b_vwb;
    logic [NCH-1:0]            b_stall;
    logic [NCH-1:0][3:0]       b_stall_cnt, b_max_run;
    logic [3:0]                b_ret;
    logic [NCH-1:0]            b_long;
    logic [1:0]                b_state;

    core_ibex_stall_tracker #(.NumStallCh(NCH), .CntWidth(16), .LongStallThresh(TH)) u_dut (
        .clk(clk), .rst_ni(rst_ni), .en_i(en_i), .clear_i(clear_i),
        .valid_id_i(valid_id_i), .valid_wb_i(valid_wb_i), .stall_id_i(stall_id_i),
        .stall_cnt_o(stall_cnt_o), .max_run_o(max_run_o), .retire_cnt_o(retire_cnt_o),
        .long_stall_o(long_stall_o), .state_o(state_o)
    );

    core_ibex_stall_tracker #(.NumStallCh(NCH), .CntWidth(4), .LongStallThresh(TH)) u_dut4 (
        .clk(clk), .rst_ni(rst_ni), .en_i(b_en), .clear_i(b_clr),
        .valid_id_i(b_vid), .valid_wb_i(b_vwb), .stall_id_i(b_stall),
        .stall_cnt_o(b_stall_cnt), .max_run_o(b_max_run), .retire_cnt_o(b_ret),
        .long_stall_o(b_long), .state_o(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 counting allowed, 2 saturated.
    int m_mode;
    int m_cnt  [NCH];
    int m_max  [NCH];
    int m_run  [NCH];
    int m_ret;
    bit m_long [NCH];

    int pulses;
    logic [NCH-1:0] rst_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_ret  = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_max[c] = 0; m_run[c] = 0; m_long[c] = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic clr, input logic vid,
                              input logic vwb, input logic [NCH-1:0] st);
        bit full;
        if (clr) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) m_long[c] = 0;
        if (m_mode == 1 && en) begin
            full = 0;
            for (int c = 0; c < NCH; c++) begin
                if (vid && st[c]) begin
                    m_run[c] = (m_run[c] + 1 > MAXA) ? MAXA : m_run[c] + 1;
                    if (m_run[c] > m_max[c]) m_max[c] = m_run[c];
                    if (m_run[c] == TH) m_long[c] = 1;
                    m_cnt[c] = (m_cnt[c] + 1 > MAXA) ? MAXA : m_cnt[c] + 1;
                    if (m_cnt[c] == MAXA) full = 1;
                end else begin
                    m_run[c] = 0;
                end
            end
            if (vwb) begin
                m_ret = (m_ret + 1 > MAXA) ? MAXA : m_ret + 1;
                if (m_ret == MAXA) full = 1;
            end
            if (full) begin
                m_mode = 2;
                for (int c = 0; c < NCH; c++) begin m_run[c] = 0; m_long[c] = 0; end
            end
        end else begin
            for (int c = 0; c < NCH; c++) m_run[c] = 0;
            if (m_mode == 0 && en) m_mode = 1;
            else if (m_mode == 1 && !en) m_mode = 0;
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state_o), 32'(m_mode));
        chk("retire", 32'(retire_cnt_o), 32'(m_ret));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("stall_cnt[%0d]", c), 32'(stall_cnt_o[c]), 32'(m_cnt[c]));
            chk($sformatf("max_run[%0d]", c), 32'(max_run_o[c]), 32'(m_max[c]));
            chk($sformatf("long_stall[%0d]", c), 32'(long_stall_o[c]), 32'(m_long[c]));
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic vid,
                        input logic vwb, input logic [NCH-1:0] st);
        en_i = en; clear_i = clr; valid_id_i = vid; valid_wb_i = vwb; stall_id_i = st;
        @(posedge clk);
        model_step(en, clr, vid, vwb, st);
        #1;
        check_all();
    endtask

    initial begin
        rst_ni = 1'b0;
        en_i = 0; clear_i = 0; valid_id_i = 0; valid_wb_i = 0; stall_id_i = '0;
        b_en = 0; b_clr = 0; b_vid = 0; b_vwb = 0; b_stall = '0;
        model_reset();
        #1;
        check_all();
        chk("b_reset_ret", 32'(b_ret), 32'd0);
        chk("b_reset_state", 32'(b_state), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b1;

        // Ten-cycle stall on channel 2.
        step(1, 0, 0, 0, '0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0, 5'b00100);
            pulses += int'(long_stall_o[2]);
            chk("ls2_timing", 32'(long_stall_o[2]), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("cnt2_10", 32'(stall_cnt_o[2]), 32'd10);
        chk("max2_10", 32'(max_run_o[2]), 32'd10);
        chk("ls2_pulses", 32'(pulses), 32'd1);
        step(1, 0, 1, 0, '0);

        // Clear while enabled from RUN, then re-enter RUN.
        step(1, 1, 1, 1, 5'b00100);
        chk("clr_state", 32'(state_o), 32'd0);
        chk("clr_cnt2", 32'(stall_cnt_o[2]), 32'd0);
        step(1, 0, 0, 0, '0);
        chk("rerun_state", 32'(state_o), 32'd1);

        // Unqualified stalls are ignored.
        repeat (6) step(1, 0, 0, 0, 5'b11111);
        for (int c = 0; c < NCH; c++) begin
            chk("unq_cnt", 32'(stall_cnt_o[c]), 32'd0);
            chk("unq_max", 32'(max_run_o[c]), 32'd0);
        end

        // Channel 0 runs of 3 and 5 separated by 2 idle cycles.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0, (i == 3 || i == 4) ? 5'b00000 : 5'b00001);
            pulses += int'(long_stall_o[0]);
        end
        chk("ch0_cnt8", 32'(stall_cnt_o[0]), 32'd8);
        chk("ch0_max5", 32'(max_run_o[0]), 32'd5);
        chk("ch0_no_pulse", 32'(pulses), 32'd0);

        // Asynchronous reset mid-run with channel 1 at 7.
        step(1, 1, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        repeat (7) step(1, 0, 1, 1, 5'b00010);
        chk("pre_rst_cnt1", 32'(stall_cnt_o[1]), 32'd7);
        #3 rst_ni = 1'b0;
        model_reset();
        #1;
        check_all();
        #2 rst_ni = 1'b1;
        step(1, 0, 0, 0, '0);
        chk("post_rst_run", 32'(state_o), 32'd1);

        // Random traffic with sticky per-channel stall causes.
        rst_st = '0;
        for (int i = 0; i < 400; i++) begin
            rst_st = rst_st ^ NCH'($urandom & $urandom);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, rst_st);
        end
        step(0, 1, 0, 0, '0);

        // Retire saturation on the 4-bit instance.
        b_en = 1;
        @(posedge clk); #1;
        chk("b_run", 32'(b_state), 32'd1);
        b_vwb = 1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            chk("b_ret", 32'(b_ret), (i < 15) ? 32'(i) : 32'd15);
            chk("b_state", 32'(b_state), (i < 15) ? 32'd1 : 32'd2);
        end
        b_clr = 1;
        @(posedge clk); #1;
        chk("b_clr_ret", 32'(b_ret), 32'd0);
        chk("b_clr_state", 32'(b_state), 32'd0);
        chk("b_clr_cnt0", 32'(b_stall_cnt[0]), 32'd0);
        b_clr = 0; b_vwb = 0; b_en = 0;
        @(posedge clk); #1;
        chk("b_idle", 32'(b_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
